// File: rtl/cnt_cmd_seq.sv
// Command sequencer for the up/down counter: expands LOAD/UP/DOWN/HOLD commands into counter controls.
// Latency: first control cycle follows the accept cycle; done pulses the cycle after the last active cycle.
// Backpressure: cmd_ready only in IDLE (and not in reset); optional macro CNT_SEQ_SAT_GUARD_EN stops runs at saturation.
module cnt_cmd_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [CNT_W-1:0] data_out,
  output logic             ld_cnt_,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic [CNT_W-1:0] data_in,
  output logic             done,
  output logic             sat_hit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  localparam logic [1:0]       OP_LOAD = 2'b00;
  localparam logic [1:0]       OP_UP   = 2'b01;
  localparam logic [1:0]       OP_DOWN = 2'b10;
  localparam logic [1:0]       OP_HOLD = 2'b11;
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             updn_q, updn_d;
  logic [CNT_W-1:0] data_in_q, data_in_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;
  logic             accept;
  logic             guard;

`ifdef CNT_SEQ_SAT_GUARD_EN
  // Stop a run when the next enable would wrap the counter in the current direction.
  assign guard = (state_q == S_RUN) &&
                 (updn_q ? (data_out == {CNT_W{1'b1}}) : (data_out == {CNT_W{1'b0}}));
`else
  logic unused_data_out;
  assign unused_data_out = ^data_out;
  assign guard = 1'b0;
`endif

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  assign ld_cnt_   = (state_q != S_LOAD);
  assign count_enb = (state_q == S_RUN) && !guard;
  assign updn_cnt  = updn_q;
  assign data_in   = data_in_q;
  assign done      = done_q;
  assign sat_hit   = sat_q;

  // Next-state and register updates for command expansion.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    updn_d    = updn_q;
    data_in_d = data_in_q;
    done_d    = 1'b0;
    sat_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: begin
              data_in_d = cmd_arg;
              state_d   = S_LOAD;
            end
            OP_UP, OP_DOWN: begin
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                rem_d   = cmd_arg;
                updn_d  = (cmd_op == OP_UP);
                state_d = S_RUN;
              end
            end
            OP_HOLD: begin
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                rem_d   = cmd_arg;
                state_d = S_HOLD;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_RUN: begin
        if (guard) begin
          rem_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
          sat_d   = 1'b1;
        end else begin
          rem_d = rem_q - ONE;
          if (rem_q == ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        rem_d = rem_q - ONE;
        if (rem_q == ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any command without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      updn_q    <= 1'b0;
      data_in_q <= '0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      updn_q    <= updn_d;
      data_in_q <= data_in_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
    end
  end

endmodule

// File: tb/tb_cnt_cmd_seq.sv
// Bench for cnt_cmd_seq: drives commands, emulates the downstream counter, and
// checks each command against a transaction-level expectation (enables, loads,
// done timing, saturation flag and resulting counter value).
module tb_cnt_cmd_seq;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;
`ifdef CNT_SEQ_SAT_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_arg = '0;
  logic [W-1:0] data_out;
  logic         ld_cnt_;
  logic         updn_cnt;
  logic         count_enb;
  logic [W-1:0] data_in;
  logic         done;
  logic         sat_hit;

  logic [W-1:0] cnt = '0;
  logic [W-1:0] exp_val = '0;
  int checks = 0;
  int errors = 0;

  cnt_cmd_seq #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .data_out(data_out),
    .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
    .data_in(data_in), .done(done), .sat_hit(sat_hit)
  );

  always #5 clk = ~clk;

  // Downstream counter emulation.
  assign data_out = cnt;
  always @(posedge clk) begin
    if (ld_cnt_ === 1'b0) cnt <= data_in;
    else if (count_enb === 1'b1) cnt <= (updn_cnt === 1'b1) ? cnt + 1'b1 : cnt - 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command in the current (idle) cycle and follow it to its done pulse.
  // Returns positioned in the done cycle so a following command is back-to-back.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] arg);
    int exp_done, exp_en, exp_ld, lim, n_en, n_ld, bad_dir, bad_ld, bad_excl, bad_sat, k;
    bit exp_sat, seen;
    logic [W-1:0] nv;
    exp_sat = 1'b0; exp_ld = 0; exp_en = 0; nv = exp_val; exp_done = 1;
    case (op)
      2'd0: begin exp_done = 2; exp_ld = 1; nv = arg; end
      2'd1, 2'd2: begin
        lim = (op == 2'd1) ? (MAX - int'(exp_val)) : int'(exp_val);
        if (GUARD && int'(arg) > lim) begin
          exp_en = lim; exp_sat = 1'b1; exp_done = lim + 2;
        end else begin
          exp_en = int'(arg); exp_done = int'(arg) + 1;
        end
        nv = (op == 2'd1) ? W'(int'(exp_val) + exp_en) : W'(int'(exp_val) - exp_en);
      end
      default: exp_done = int'(arg) + 1;
    endcase

    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tick();
    cmd_valid = 1'b0; cmd_arg = W'($urandom);
    n_en = 0; n_ld = 0; bad_dir = 0; bad_ld = 0; bad_excl = 0; bad_sat = 0;
    seen = 1'b0; k = 1;
    while (!seen && k <= 400) begin
      if (ld_cnt_ === 1'b0) begin
        n_ld++;
        if (data_in !== arg) bad_ld++;
      end
      if (count_enb === 1'b1) begin
        n_en++;
        if (updn_cnt !== (op == 2'd1)) bad_dir++;
      end
      if (ld_cnt_ === 1'b0 && count_enb === 1'b1) bad_excl++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (sat_hit !== 1'b0) bad_sat++;
        tick();
        k++;
      end
    end
    chk("done_seen", seen, 1);
    chk("done_latency", k, exp_done);
    chk("enable_cycles", n_en, exp_en);
    chk("load_cycles", n_ld, exp_ld);
    chk("sat_hit_at_done", sat_hit, exp_sat);
    chk("ld_enb_exclusive", bad_excl, 0);
    chk("stray_sat_or_dir_or_data", bad_sat + bad_dir + bad_ld, 0);
    chk("counter_value", data_out, nv);
    exp_val = nv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("done_low_idle", done, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    // Reset held for 3 cycles with a command offered.
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_ld_cnt_", ld_cnt_, 1);
      chk("rst_count_enb", count_enb, 0);
      chk("rst_done", done, 0);
    end
    chk("rst_updn", updn_cnt, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_sat", sat_hit, 0);
    rst = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("ready_after_release", cmd_ready, 1);

    // Directed commands.
    run_cmd(2'd0, 8'h5A);
    idle(1);
    run_cmd(2'd0, 8'h10);
    run_cmd(2'd1, 8'd5);
    run_cmd(2'd3, 8'd3);
    run_cmd(2'd2, 8'd0);
    idle(2);

    // Reset during the second cycle of UP 10.
    chk("ready_before_up10", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 8'd10;
    tick();
    cmd_valid = 1'b0;
    chk("up10_enb_c1", count_enb, 1);
    tick();
    chk("up10_enb_c2", count_enb, 1);
    rst = 1'b1;
    tick();
    chk("abort_enb_low", count_enb, 0);
    chk("abort_no_done", done, 0);
    chk("abort_no_sat", sat_hit, 0);
    rst = 1'b0;
    #1;
    chk("abort_ready", cmd_ready, 1);
    exp_val = exp_val + 8'd2;
    idle(2);
    chk("abort_counter_value", data_out, exp_val);

    // Saturation boundaries in both directions.
    run_cmd(2'd0, 8'hFD);
    run_cmd(2'd1, 8'd6);
    run_cmd(2'd0, 8'h02);
    run_cmd(2'd2, 8'd5);
    run_cmd(2'd1, 8'd0);
    run_cmd(2'd3, 8'd1);
    idle(1);

    // Randomized command stream, with loads biased toward the wrap edges.
    for (int n = 0; n < 60; n++) begin
      logic [1:0]   op;
      logic [W-1:0] arg;
      op = 2'($urandom_range(0, 3));
      if (op == 2'd0) begin
        case ($urandom_range(0, 2))
          0: arg = W'($urandom_range(MAX - 4, MAX));
          1: arg = W'($urandom_range(0, 4));
          default: arg = W'($urandom);
        endcase
      end else begin
        arg = W'($urandom_range(0, 12));
      end
      run_cmd(op, arg);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cnt_cmd_seq.md
# cnt_cmd_seq

Command sequencer directly upstream of the 8-bit up/down counter. It accepts high-level commands over a valid/ready handshake: load a value, count up N steps, count down N steps, or hold N cycles. It expands each command into the counter's cycle-level controls (`ld_cnt_`, `updn_cnt`, `count_enb`, `data_in`). Optionally it watches the counter's `data_out` to stop a run before the count wraps.

## Interface
- `CNT_W`, default 8: counter / argument width.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 2: operation code. 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- `cmd_arg` in CNT_W: load value (LOAD) or step/cycle count N (UP/DOWN/HOLD).
- `data_out` in CNT_W: counter output; used only by the saturation guard.
- `ld_cnt_` out 1: counter load, active-low.
- `updn_cnt` out 1: 1 = up, 0 = down.
- `count_enb` out 1: counter enable.
- `data_in` out CNT_W: counter load data.
- `done` out 1: one-cycle pulse when a command completes.
- `sat_hit` out 1: one-cycle pulse together with `done` when the guard ended the command early.

## Operation
- FSM states are IDLE, LOAD, RUN and HOLD. There is an internal remaining-count register `rem` (CNT_W bits).
- Accept: `cmd_valid && cmd_ready`. `cmd_ready = (state==IDLE) && !rst`. Commands are only accepted in IDLE.
- On accepting a LOAD:
  - `data_in <= cmd_arg`, then go to LOAD.
  - LOAD lasts exactly 1 cycle with `ld_cnt_=0`, `count_enb=0`, then returns to IDLE.
- On accepting UP or DOWN with N≠0:
  - `rem <= N`, `updn_cnt <= (op==UP)`, then go to RUN.
  - RUN drives `count_enb=1`, `ld_cnt_=1` and decrements `rem` each cycle.
  - When RUN finishes the cycle with `rem==1`, go to IDLE. This gives exactly N enable cycles.
- On accepting HOLD with N≠0:
  - `rem <= N`, then go to HOLD.
  - HOLD drives `ld_cnt_=1`, `count_enb=0` for exactly N cycles, then returns to IDLE.
- N==0 for UP/DOWN/HOLD: no active cycle. The FSM stays in IDLE and `done` pulses on the next cycle.
- `updn_cnt` and `data_in` are registered. They hold their last value in all states other than the state that sets them.
- `done` is registered and high for exactly the first IDLE cycle after a command finishes. `cmd_ready` is also high in that cycle, so back-to-back commands are legal.
- Counting wraps modulo 2^CNT_W in the counter. Without the guard, the sequencer does not observe overflow.
- Reset mid-command:
  - Aborts the command immediately. FSM returns to IDLE.
  - No `done` and no `sat_hit`.
  - `rem` is cleared.
- Any `cmd_valid` while not ready is ignored. The source must hold the command stable until it is accepted.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - `ld_cnt_=1`, `updn_cnt=0`, `count_enb=0`, `data_in=0`
  - `done=0`, `sat_hit=0`, state IDLE, `rem=0`
  - `cmd_ready=0` while `rst` is high.
- Accept at cycle T: first active control cycle is T+1. The counter samples it at the edge ending T+1.
- LOAD: `ld_cnt_` low during T+1; `done` at T+2; next accept possible at T+2.
- UP/DOWN/HOLD with N: active T+1 .. T+N; `done` at T+N+1.
- `ld_cnt_` and `count_enb` are never active in the same cycle.
- All outputs are registered, except `count_enb` gating when the guard is enabled (see Configuration).

## Configuration
- `CNT_SEQ_SAT_GUARD_EN` defined:
  - In RUN, `count_enb = run_q && !guard`. `guard` is `(data_out=={CNT_W{1'b1}})` when counting up and `(data_out==0)` when counting down. This is a combinational path from `data_out`.
  - On the first RUN cycle where `guard` is true, the enable is suppressed and the FSM goes to IDLE. `done` and `sat_hit` both pulse in the next cycle.
- `CNT_SEQ_SAT_GUARD_EN` undefined:
  - `data_out` is ignored and `sat_hit` is tied 0.
  - RUN always issues exactly N enables, so the counter wraps freely.

## Test plan
- Reset: hold `rst=1` for 3 cycles with `cmd_valid=1` -> `cmd_ready=0`, `ld_cnt_=1`, `count_enb=0`, no `done`. After release, `cmd_ready=1` in the first cycle.
- LOAD 8'h5A accepted at T -> `ld_cnt_=0` and `data_in=8'h5A` at T+1 only; `done` at T+2; counter `data_out=8'h5A`.
- LOAD 8'h10, then UP 5 back-to-back (UP accepted in the LOAD `done` cycle) -> `count_enb` high for exactly 5 cycles with `updn_cnt=1`; `data_out=8'h15`; one `done` per command.
- HOLD 3 then DOWN 0 -> `count_enb=0` for 3 cycles with `data_out` stable; DOWN 0 gives `done` one cycle after accept with no enable.
- Reset asserted on the 2nd cycle of UP 10 -> `count_enb` drops the next cycle; no `done`; `cmd_ready=1` after release.
- Guard: LOAD 8'hFD, UP 6 -> with `CNT_SEQ_SAT_GUARD_EN`, exactly 2 enables, `data_out=8'hFF`, `done`+`sat_hit` together. Without it, 6 enables, `data_out=8'h03`, `sat_hit=0`.
